// File: rtl/prio_arbiter_reg.sv
// prio_arbiter_reg: registered N-way request arbiter with fixed-priority
// (highest index wins) and round-robin modes. A winner is latched and held
// until the holder acknowledges. All outputs come from flops.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no grant held; arbitrates req each cycle while en=1
// S_GRANT | grant_idx latched and held until ack=1 is sampled
module prio_arbiter_reg #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             idle
);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] winner;
    logic             idle_q;

    // Winner from the current request vector: highest set bit in fixed mode,
    // first set bit at or above rr_ptr (wrapping) in round-robin mode.
    always_comb begin
        int j;
        winner = '0;
        j      = 0;
        if (!mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) winner = IDX_W'(i);
            end
        end else begin
            // Scan from the far end so the nearest hit to rr_ptr is assigned last.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= N_REQ) j = j - N_REQ;
                if (req[j]) winner = IDX_W'(j);
            end
        end
    end

    // Pointer advances past the released holder; explicit wrap keeps it below
    // N_REQ for non-power-of-2 channel counts.
    always_comb begin
        ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (en && (req != '0)) state_next = S_GRANT;
            S_GRANT: if (ack)               state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    // State register plus the latched grant index, idle flag and rr pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            idle_q    <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (en && (req != '0)) grant_idx <= winner;
                    idle_q <= en && (req == '0);
                end
                S_GRANT: begin
                    idle_q <= 1'b0;
                    if (ack) rr_ptr <= ptr_next;
                end
                default: idle_q <= 1'b0;
            endcase
        end
    end

    // Outputs decoded purely from registers; grant_idx keeps its value after release.
    always_comb begin
        grant_valid  = (state == S_GRANT);
        idle         = idle_q;
        grant_onehot = '0;
        if (state == S_GRANT) grant_onehot[grant_idx] = 1'b1;
    end

endmodule

// File: tb/tb_prio_arbiter_reg.sv
// Testbench for prio_arbiter_reg: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_prio_arbiter_reg;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset, en, mode, ack;
    logic [N-1:0] req;
    logic         grant_valid;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_onehot;
    logic         idle;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    bit m_idle;
    int m_ptr;

    prio_arbiter_reg #(.N_REQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .req          (req),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    function automatic int model_winner(input logic [N-1:0] r, input logic md, input int ptr);
        if (!md) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_edge();
        if (reset) begin
            m_valid = 0; m_idx = 0; m_idle = 0; m_ptr = 0;
        end else if (!m_valid) begin
            if (en && req != 0) begin
                m_valid = 1;
                m_idx   = model_winner(req, mode, m_ptr);
                m_idle  = 0;
            end else begin
                m_idle = en;
            end
        end else begin
            m_idle = 0;
            if (ack) begin
                m_valid = 0;
                m_ptr   = (m_idx + 1) % N;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] exp_oh;
        exp_oh = m_valid ? (N'(1) << m_idx) : '0;
        check("grant_valid", 32'(grant_valid), 32'(m_valid));
        check("grant_idx", 32'(grant_idx), 32'(m_idx));
        check("grant_onehot", 32'(grant_onehot), 32'(exp_oh));
        check("idle", 32'(idle), 32'(m_idle));
    endtask

    // Apply inputs, clock once, update model, sample 1 ns after the edge.
    task automatic step(input logic r, input logic e, input logic md,
                        input logic [N-1:0] rq, input logic a);
        reset = r; en = e; mode = md; req = rq; ack = a;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        reset = 1; en = 1; mode = 0; req = 8'hFF; ack = 0;
        m_valid = 0; m_idx = 0; m_idle = 0; m_ptr = 0;
        @(negedge clk);

        // Reset with all requests pending, then first grant
        step(1, 1, 0, 8'hFF, 0);
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_onehot", 32'(grant_onehot), 0);
        step(0, 1, 0, 8'hFF, 0);
        check("first_idx", 32'(grant_idx), 7);
        step(0, 1, 0, 8'hFF, 1);

        // Fixed priority picks bit 6 of 0100_1000
        step(1, 1, 0, 8'h00, 0);
        step(0, 1, 0, 8'h48, 0);
        check("fix_idx", 32'(grant_idx), 6);
        check("fix_oh", 32'(grant_onehot), 32'h40);
        step(0, 1, 0, 8'h48, 1);
        check("fix_gap", 32'(grant_valid), 0);
        step(0, 1, 0, 8'h48, 0);
        check("fix_regrant", 32'(grant_idx), 6);
        step(0, 1, 0, 8'h48, 1);

        // Round-robin over all requests: 0..7 then wrap to 0
        step(1, 1, 1, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 8'hFF, 0);
            check("rr_seq", 32'(grant_idx), 32'(i % N));
            step(0, 1, 1, 8'hFF, 1);
        end

        // Pointer at 6 after granting 5, then wrap to 0 and next to 2
        step(1, 1, 1, 8'h00, 0);
        step(0, 1, 1, 8'h20, 0);
        check("rr_five", 32'(grant_idx), 5);
        step(0, 1, 1, 8'h20, 1);
        step(0, 1, 1, 8'h05, 0);
        check("rr_wrap", 32'(grant_idx), 0);
        step(0, 1, 1, 8'h05, 1);
        step(0, 1, 1, 8'h05, 0);
        check("rr_next", 32'(grant_idx), 2);
        step(0, 1, 1, 8'h05, 1);

        // Grant held through input churn without ack, then reset drops it
        step(1, 1, 0, 8'h00, 0);
        step(0, 1, 0, 8'h08, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, logic'(i % 2), logic'((i + 1) % 2), 8'(i * 37), 0);
            check("hold_idx", 32'(grant_idx), 3);
            check("hold_valid", 32'(grant_valid), 1);
        end
        step(1, 1, 0, 8'h00, 0);
        check("rst_drop", 32'(grant_valid), 0);

        // idle behaviour and enable gating
        step(0, 1, 0, 8'h00, 0);
        check("idle_hi", 32'(idle), 1);
        step(0, 0, 0, 8'h10, 0);
        check("en_off_idle", 32'(idle), 0);
        check("en_off_valid", 32'(grant_valid), 0);
        step(0, 1, 0, 8'h10, 0);
        check("en_on_idx", 32'(grant_idx), 4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) != 0),
                 logic'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prio_arbiter_reg.md
Name: prio_arbiter_reg

Overview:
- Parametrised, clocked successor to the 8-input combinational priority encoder.
- Arbitrates N_REQ active-high request lines and selects one winner in either of two modes:
  - fixed priority: highest index wins;
  - round-robin: rotating pointer.
- Registers the winner and holds it until the requester acknowledges.
- Feeds shared-resource selection logic: shared bus mux, display driver, peripheral select.

Parameters:
- N_REQ, 8: number of request channels; legal range 2..32.
- IDX_W, $clog2(N_REQ): width of the encoded grant index; derived, not overridden.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: arbitration enable; gates new arbitration only.
- mode, input, 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- req, input, N_REQ: request vector, active-high, bit i = channel i.
- ack, input, 1: grant holder done; sampled only while grant_valid=1.
- grant_valid, output, 1: a grant is active (group-select equivalent).
- grant_idx, output, IDX_W: encoded index of granted channel.
- grant_onehot, output, N_REQ: one-hot form of grant_idx; all zero when no grant.
- idle, output, 1: enabled but nothing requested (enable-out equivalent).

Behaviour:
- Reset applies on a clk edge with reset=1 and overrides everything. After that edge:
  - state = IDLE;
  - grant_valid, grant_idx, grant_onehot and idle are all 0;
  - rr_ptr = 0.
- Reset asserted mid-grant drops the grant at that edge. No ack is needed.
- All outputs are registered. There are no combinational input-to-output paths.
- FSM states: IDLE, GRANT.
- IDLE with en=1 and req≠0:
  - compute the winner from req and mode in that cycle;
  - next edge: state = GRANT, grant_valid = 1, grant_idx/onehot = winner, idle = 0.
  - Latency from request sampled to grant visible is 1 clock.
- IDLE with en=1 and req=0: next edge idle = 1, grant_valid = 0.
- IDLE with en=0: next edge idle = 0, grant_valid = 0. req is ignored.
- GRANT:
  - grant_idx/onehot stay stable until ack=1 is sampled.
  - req, en and mode changes have no effect during GRANT.
  - A requester that drops req without ack keeps its grant.
- GRANT with ack=1, at the next edge:
  - state = IDLE, grant_valid = 0, grant_onehot = 0;
  - grant_idx holds its last value;
  - rr_ptr = (grant_idx + 1) mod N_REQ, in both modes.
- Minimum spacing between consecutive grants is 2 clocks. grant_valid is low for exactly 1 cycle between back-to-back grants.
- ack while in IDLE is ignored.
- Fixed mode winner: highest set bit of req.
- Round-robin winner: first set bit found scanning upward from rr_ptr, wrapping from index N_REQ-1 to index 0.
  - If req[rr_ptr] is set, it wins.
- mode is sampled only at the arbitration edge. A mode change mid-grant takes effect on the next arbitration.
- rr_ptr wraps modulo N_REQ. For non-power-of-2 N_REQ, the pointer never holds a value ≥ N_REQ.
- Invariant: grant_onehot == (1 << grant_idx) when grant_valid=1; grant_onehot = 0 otherwise.

Test Plan:
- Reset with req=8'hFF, en=1 → all outputs 0. One clock after reset deasserts: grant_valid=1, grant_idx=7 (fixed mode).
- Fixed mode, req=8'b0100_1000, ack one cycle after grant → grant_idx=6, onehot=8'h40. After ack: grant_valid=0 for 1 cycle, then grant_idx=6 again.
- Round-robin, req=8'hFF held, ack every grant → grant_idx sequence 0,1,2,…,7,0; pointer wraps cleanly.
- Round-robin, rr_ptr=6 (after granting 5), req=8'b0000_0101 → grant_idx=0 (wrap). The next grant is 2.
- In GRANT with idx=3: drop req, toggle mode and en for 5 cycles without ack → grant_idx stays 3 and grant_valid stays 1. Assert reset → grant_valid=0 at that edge.
- en=1, req=0 → idle=1 after 1 clock. en=0 with req=8'h10 → no grant and idle=0. Raise en → grant_idx=4 one clock later.
